// File: rtl/divisor_arbitro.sv
// divisor_arbitro: round-robin front end that shares one signed iterative
// divider among N_REQ requesters. Zero divisors are answered locally
// (quotient all ones, remainder = dividend) without starting the divider.
// Optional build macro DIVARB_TIMEOUT_EN adds a WAIT watchdog that answers
// with rsp_err=1 after TIMEOUT cycles without div_Done.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | no transaction; round-robin grant of the next pending request
// ISSUE | one-cycle div_Start pulse with the latched operands
// WAIT  | waiting for div_Done (or the watchdog, if built)
// RESP  | result presented on rsp_*; waiting for the owner's rsp_ack
module divisor_arbitro #(
    parameter int tamanyo = 32,
    parameter int N_REQ   = 4,
    parameter int IDX_W   = 2,
    parameter int TIMEOUT = 63
) (
    input  logic                       CLK,
    input  logic                       RSTa,
    input  logic [N_REQ-1:0]           req_valid,
    input  logic [N_REQ*tamanyo-1:0]   req_num,
    input  logic [N_REQ*tamanyo-1:0]   req_den,
    output logic [N_REQ-1:0]           req_ready,
    output logic [N_REQ-1:0]           rsp_valid,
    input  logic [N_REQ-1:0]           rsp_ack,
    output logic [tamanyo-1:0]         rsp_coc,
    output logic [tamanyo-1:0]         rsp_rec,
    output logic                       rsp_div0,
    output logic                       rsp_err,
    output logic                       busy,
    output logic                       div_Start,
    output logic [tamanyo-1:0]         div_Num,
    output logic [tamanyo-1:0]         div_Den,
    input  logic [tamanyo-1:0]         div_Coc,
    input  logic [tamanyo-1:0]         div_Rec,
    input  logic                       div_Done
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t              state, state_d;
    logic [IDX_W-1:0]    rr_ptr, g_q, gnt_idx, cand;
    logic                gnt_vld;
    logic [tamanyo-1:0]  num_q, den_q, gnt_num, gnt_den;
    logic                timeout_hit;

    if (IDX_W != $clog2(N_REQ) || TIMEOUT < 1) begin : g_param_check
        $error("divisor_arbitro: IDX_W must equal clog2(N_REQ) and TIMEOUT must be >= 1");
    end

    // Round-robin search starting just after the last granted requester.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        cand    = '0;
        for (int i = 1; i <= N_REQ; i++) begin
            cand = IDX_W'((int'(rr_ptr) + i) % N_REQ);
            if (!gnt_vld && req_valid[cand]) begin
                gnt_vld = 1'b1;
                gnt_idx = cand;
            end
        end
    end

    assign gnt_num = req_num[int'(gnt_idx)*tamanyo +: tamanyo];
    assign gnt_den = req_den[int'(gnt_idx)*tamanyo +: tamanyo];

    // Next-state and handshake outputs; req_ready is gated by reset so every output is 0 while RSTa is low.
    always_comb begin
        state_d   = state;
        req_ready = '0;
        rsp_valid = '0;
        div_Start = 1'b0;
        case (state)
            IDLE: begin
                if (gnt_vld && RSTa) begin
                    req_ready[gnt_idx] = 1'b1;
                    state_d = (gnt_den == '0) ? RESP : ISSUE;
                end
            end
            ISSUE: begin
                div_Start = 1'b1;
                state_d   = WAIT;
            end
            WAIT: begin
                if (div_Done || timeout_hit) state_d = RESP;
            end
            RESP: begin
                rsp_valid[g_q] = 1'b1;
                if (rsp_ack[g_q]) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge CLK or negedge RSTa) begin
        if (!RSTa) state <= IDLE;
        else       state <= state_d;
    end

    // Grant bookkeeping, operand latches and result capture.
    always_ff @(posedge CLK or negedge RSTa) begin
        if (!RSTa) begin
            rr_ptr   <= IDX_W'(N_REQ - 1);
            g_q      <= '0;
            num_q    <= '0;
            den_q    <= '0;
            rsp_coc  <= '0;
            rsp_rec  <= '0;
            rsp_div0 <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (gnt_vld) begin
                        rr_ptr <= gnt_idx;
                        g_q    <= gnt_idx;
                        num_q  <= gnt_num;
                        den_q  <= gnt_den;
                        if (gnt_den == '0) begin
                            rsp_coc  <= '1;
                            rsp_rec  <= gnt_num;
                            rsp_div0 <= 1'b1;
                        end
                    end
                end
                WAIT: begin
                    if (div_Done) begin
                        rsp_coc  <= div_Coc;
                        rsp_rec  <= div_Rec;
                        rsp_div0 <= 1'b0;
                    end else if (timeout_hit) begin
                        rsp_coc  <= '0;
                        rsp_rec  <= '0;
                        rsp_div0 <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy    = (state != IDLE);
    assign div_Num = (state == ISSUE || state == WAIT) ? num_q : '0;
    assign div_Den = (state == ISSUE || state == WAIT) ? den_q : '0;

`ifdef DIVARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] wd_cnt;
    logic             err_q;

    // Watchdog fires on the cycle the count would reach TIMEOUT, so RESP starts TIMEOUT+1 cycles after div_Start.
    assign timeout_hit = (state == WAIT) && (wd_cnt == CNT_W'(TIMEOUT - 1));

    // Watchdog counter and error flag; div_Done wins over a same-cycle timeout.
    always_ff @(posedge CLK or negedge RSTa) begin
        if (!RSTa) begin
            wd_cnt <= '0;
            err_q  <= 1'b0;
        end else begin
            case (state)
                IDLE:  if (gnt_vld) err_q <= 1'b0;
                ISSUE: wd_cnt <= '0;
                WAIT: begin
                    wd_cnt <= wd_cnt + 1'b1;
                    if (div_Done)         err_q <= 1'b0;
                    else if (timeout_hit) err_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign rsp_err = err_q;
`else
    assign timeout_hit = 1'b0;
    assign rsp_err     = 1'b0;
`endif

endmodule

// File: tb/tb_divisor_arbitro.sv
// Testbench for divisor_arbitro: directed requests, scoreboard of expected
// responses checked by an independent monitor, behavioural divider model.
module tb_divisor_arbitro;

    logic          CLK = 1'b0;
    logic          RSTa;
    logic [3:0]    req_valid;
    logic [127:0]  req_num, req_den;
    logic [3:0]    req_ready, rsp_valid, rsp_ack;
    logic [31:0]   rsp_coc, rsp_rec;
    logic          rsp_div0, rsp_err, busy, div_Start;
    logic [31:0]   div_Num, div_Den, div_Coc, div_Rec;
    logic          div_Done;

    divisor_arbitro dut (
        .CLK(CLK), .RSTa(RSTa),
        .req_valid(req_valid), .req_num(req_num), .req_den(req_den),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_ack(rsp_ack),
        .rsp_coc(rsp_coc), .rsp_rec(rsp_rec), .rsp_div0(rsp_div0), .rsp_err(rsp_err),
        .busy(busy), .div_Start(div_Start), .div_Num(div_Num), .div_Den(div_Den),
        .div_Coc(div_Coc), .div_Rec(div_Rec), .div_Done(div_Done)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int          idx;
        logic [31:0] coc;
        logic [31:0] rec;
        logic        div0;
        logic        err;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   start_cnt = 0;
    int   t_start = 0, t_resp = 0;
    int   resp_len = 0;
    int   ack_delay = 0;
    bit   prev_v = 0;
    bit   model_en = 1;
    bit   stale = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        total++;
        if (act !== exp_v) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp_v);
        end
    endtask

    task automatic fail_now(input string nm);
        total++;
        bad++;
        $display("FAIL %s: got no event, expected one within the cycle bound", nm);
    endtask

    always @(posedge CLK) cyc++;

    // Divider model: result 3 cycles after the start pulse; 'stale' forces a bogus Done.
    logic signed [31:0] m_n, m_d;
    int m_cnt = 0;
    bit m_pend = 0;
    always @(negedge CLK) begin
        div_Done = 1'b0;
        if (stale) begin
            div_Done = 1'b1;
            div_Coc  = 32'h0BAD;
            div_Rec  = 32'h0BAD;
        end
        if (m_pend) begin
            if (m_cnt == 0) begin
                m_pend = 0;
                if (model_en) begin
                    div_Done = 1'b1;
                    div_Coc  = m_n / m_d;
                    div_Rec  = m_n % m_d;
                end
            end else m_cnt--;
        end
        if (div_Start) begin
            m_pend = 1;
            m_cnt  = 2;
            m_n    = div_Num;
            m_d    = div_Den;
            start_cnt++;
            stale  = 0;
        end
    end

    // Response monitor: checks each new response against the scoreboard and drives rsp_ack.
    always @(negedge CLK) begin
        if (RSTa && rsp_valid != '0) begin
            if (!prev_v) begin
                resp_len = 1;
                t_resp   = cyc;
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_rsp: got rsp_valid=%0h, expected no response", rsp_valid);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("rsp_valid", 32'(rsp_valid), 32'(1) << e.idx);
                    chk("rsp_coc", rsp_coc, e.coc);
                    chk("rsp_rec", rsp_rec, e.rec);
                    chk("rsp_div0", 32'(rsp_div0), 32'(e.div0));
                    chk("rsp_err", 32'(rsp_err), 32'(e.err));
                end
            end else resp_len++;
            rsp_ack = (resp_len <= ack_delay) ? ~rsp_valid : rsp_valid;
            prev_v  = 1;
        end else begin
            prev_v  = 0;
            rsp_ack = '0;
        end
    end

    task automatic wait_idle();
        bit done = 0;
        for (int k = 0; k < 300 && !done; k++) begin
            @(negedge CLK);
            if (!busy && rsp_valid == '0) done = 1;
        end
        if (!done) fail_now("idle_wait");
    endtask

    task automatic check_reset_outputs(input string pfx);
        chk({pfx, "_req_ready"}, 32'(req_ready), 0);
        chk({pfx, "_rsp_valid"}, 32'(rsp_valid), 0);
        chk({pfx, "_rsp_coc"}, rsp_coc, 0);
        chk({pfx, "_rsp_rec"}, rsp_rec, 0);
        chk({pfx, "_rsp_div0"}, 32'(rsp_div0), 0);
        chk({pfx, "_rsp_err"}, 32'(rsp_err), 0);
        chk({pfx, "_busy"}, 32'(busy), 0);
        chk({pfx, "_div_Start"}, 32'(div_Start), 0);
        chk({pfx, "_div_Num"}, div_Num, 0);
        chk({pfx, "_div_Den"}, div_Den, 0);
    endtask

    task automatic do_req(input int idx, input logic [31:0] num, input logic [31:0] den,
                          input logic [31:0] ecoc, input logic [31:0] erec,
                          input logic ediv0, input logic eerr);
        exp_t e;
        bit got = 0;
        e.idx = idx; e.coc = ecoc; e.rec = erec; e.div0 = ediv0; e.err = eerr;
        sb.push_back(e);
        @(posedge CLK);
        #1;
        req_num[idx*32 +: 32] = num;
        req_den[idx*32 +: 32] = den;
        req_valid[idx] = 1'b1;
        for (int k = 0; k < 100 && !got; k++) begin
            @(negedge CLK);
            if (req_ready[idx]) got = 1;
        end
        if (!got) begin
            fail_now("grant_wait");
            req_valid[idx] = 1'b0;
            return;
        end
        chk("req_ready", 32'(req_ready), 32'(1) << idx);
        @(posedge CLK);
        #1 req_valid[idx] = 1'b0;
        @(negedge CLK);
        chk("div_Start", 32'(div_Start), (den != 0) ? 32'd1 : 32'd0);
        if (den != 0) begin
            chk("div_Num", div_Num, num);
            chk("div_Den", div_Den, den);
            t_start = cyc;
        end else begin
            chk("div0_latency", 32'(rsp_valid), 32'(1) << idx);
        end
        wait_idle();
    endtask

    initial begin
        int sc;
        int glog[$];
        int exp_order[5] = '{0, 1, 2, 3, 0};
        bit got;

        RSTa = 1'b0;
        req_valid = '0; req_num = '0; req_den = '0;
        repeat (2) @(negedge CLK);
        check_reset_outputs("reset");
        RSTa = 1'b1;

        do_req(0, 100, 7, 14, 2, 1'b0, 1'b0);
        do_req(1, -100, 7, -14, -2, 1'b0, 1'b0);

        ack_delay = 2;
        do_req(3, 7, -2, -3, 1, 1'b0, 1'b0);
        chk("wrong_ack_ignored", 32'(resp_len), 3);
        ack_delay = 0;

        sc = start_cnt;
        do_req(2, 55, 0, 32'hFFFF_FFFF, 55, 1'b1, 1'b0);
        chk("div0_no_start", 32'(start_cnt), 32'(sc));

        // Reset while WAIT: the transaction is dropped without a response.
        @(posedge CLK);
        #1;
        model_en = 0;
        req_num[3*32 +: 32] = 9;
        req_den[3*32 +: 32] = 3;
        req_valid[3] = 1'b1;
        got = 0;
        for (int k = 0; k < 100 && !got; k++) begin
            @(negedge CLK);
            if (req_ready[3]) got = 1;
        end
        if (!got) fail_now("abort_grant_wait");
        @(posedge CLK);
        #1 req_valid[3] = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        chk("busy_before_abort", 32'(busy), 1);
        RSTa = 1'b0;
        #1;
        check_reset_outputs("midop_reset");
        repeat (3) @(negedge CLK);
        RSTa = 1'b1;
        model_en = 1;
        stale = 1;
        do_req(2, 50, 6, 8, 2, 1'b0, 1'b0);

        // Round robin with all four requesters held, starting from a fresh reset.
        @(negedge CLK);
        RSTa = 1'b0;
        repeat (2) @(negedge CLK);
        RSTa = 1'b1;
        @(posedge CLK);
        #1;
        sb.push_back('{0, 32'd6, 32'd2, 1'b0, 1'b0});
        sb.push_back('{1, 32'd7, 32'd0, 1'b0, 1'b0});
        sb.push_back('{2, 32'd7, 32'd1, 1'b0, 1'b0});
        sb.push_back('{3, 32'd7, 32'd2, 1'b0, 1'b0});
        sb.push_back('{0, 32'd6, 32'd2, 1'b0, 1'b0});
        for (int i = 0; i < 4; i++) begin
            req_num[i*32 +: 32] = 32'(20 + i);
            req_den[i*32 +: 32] = 32'd3;
        end
        req_valid = 4'hF;
        for (int k = 0; k < 400 && glog.size() < 5; k++) begin
            @(negedge CLK);
            for (int j = 0; j < 4; j++)
                if (req_ready[j]) glog.push_back(j);
        end
        @(posedge CLK);
        #1 req_valid = '0;
        wait_idle();
        chk("rr_grant_count", 32'(glog.size()), 5);
        for (int i = 0; i < 5 && i < glog.size(); i++)
            chk($sformatf("rr_grant_%0d", i), 32'(glog[i]), 32'(exp_order[i]));

`ifdef DIVARB_TIMEOUT_EN
        model_en = 0;
        do_req(1, 10, 2, 0, 0, 1'b0, 1'b1);
        chk("timeout_latency", 32'(t_resp - t_start), 64);
        stale = 1;
        repeat (3) @(negedge CLK);
        stale = 0;
        repeat (3) @(negedge CLK);
        model_en = 1;
`endif

        repeat (4) @(negedge CLK);
        chk("scoreboard_drained", 32'(sb.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish, expected finish before 200000");
        $fatal(1);
    end

endmodule
